// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory port between the icache refill
// engine and the dcache refill/write-back engine. Each grant is a locked
// burst of BURST_LEN beats, starting at the requester's address aligned
// down to the burst block. Ties in IDLE are settled round-robin.
//
// Build option: define MEM_ARB_FIXED_PRIO_EN to give the dcache every tie.
// The icache can then starve while the dcache keeps requesting.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   IC_REQ/ADR_SI         icache request and miss address (held until DONE)
//   IC_GNT/RDATA/VALID/DONE_SA  icache grant, read beat, beat strobe, last beat
//   DC_REQ/WE/ADR/WDATA_SI      dcache request, write-back flag, address, write word
//   DC_GNT/RDATA/VALID/DONE_SA  dcache grant, read beat, beat strobe, last beat
//   MEM_REQ/WE/ADR/WDATA_SA     memory beat request
//   MEM_ACK_SM, MEM_RDATA_SM    memory beat acknowledge and read data
module mem_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int ADR_W     = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              IC_REQ_SI,
  input  logic [ADR_W-1:0]  IC_ADR_SI,
  output logic              IC_GNT_SA,
  output logic [DATA_W-1:0] IC_RDATA_SA,
  output logic              IC_VALID_SA,
  output logic              IC_DONE_SA,
  input  logic              DC_REQ_SI,
  input  logic              DC_WE_SI,
  input  logic [ADR_W-1:0]  DC_ADR_SI,
  input  logic [DATA_W-1:0] DC_WDATA_SI,
  output logic              DC_GNT_SA,
  output logic [DATA_W-1:0] DC_RDATA_SA,
  output logic              DC_VALID_SA,
  output logic              DC_DONE_SA,
  output logic              MEM_REQ_SA,
  output logic              MEM_WE_SA,
  output logic [ADR_W-1:0]  MEM_ADR_SA,
  output logic [DATA_W-1:0] MEM_WDATA_SA,
  input  logic              MEM_ACK_SM,
  input  logic [DATA_W-1:0] MEM_RDATA_SM
);

  localparam int              BEAT_W   = $clog2(BURST_LEN);
  localparam int              STRIDE   = DATA_W / 8;
  localparam logic [ADR_W-1:0] BLK_MASK = ADR_W'(BURST_LEN * STRIDE - 1);

  typedef enum logic [1:0] {IDLE, IC_BURST, DC_BURST} state_e;

  state_e             state, state_nxt;
  logic [BEAT_W-1:0]  beat;
  logic [ADR_W-1:0]   base;
  logic               we;
  logic               pick_ic, pick_dc;
  logic               beat_ack, last_beat;
  logic [ADR_W-1:0]   beat_adr;

  // Ack only counts while a burst owns the port; stray acks in IDLE are dropped.
  assign beat_ack  = (state != IDLE) && MEM_ACK_SM;
  assign last_beat = (beat == BEAT_W'(BURST_LEN - 1));
  assign beat_adr  = base + ADR_W'(beat) * ADR_W'(STRIDE);

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign pick_dc = DC_REQ_SI;
`else
  // last_dc = 1 when the dcache owned the most recent burst; reset value
  // hands the first tie to the icache.
  logic last_dc;
  assign pick_dc = DC_REQ_SI && (!IC_REQ_SI || !last_dc);
`endif
  assign pick_ic = IC_REQ_SI && !pick_dc;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_ic)      state_nxt = IC_BURST;
        else if (pick_dc) state_nxt = DC_BURST;
      end
      IC_BURST, DC_BURST: if (beat_ack && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Burst context: latched on the IDLE->burst transition so the requester's
  // address/we may change freely once granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat <= '0;
      base <= '0;
      we   <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_dc <= 1'b1;
`endif
    end else if (state == IDLE) begin
      beat <= '0;
      if (pick_ic) begin
        base <= IC_ADR_SI & ~BLK_MASK;
        we   <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_dc <= 1'b0;
`endif
      end else if (pick_dc) begin
        base <= DC_ADR_SI & ~BLK_MASK;
        we   <= DC_WE_SI;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_dc <= 1'b1;
`endif
      end
    end else if (beat_ack) begin
      beat <= last_beat ? '0 : beat + 1'b1;
    end
  end

  // Outputs: all zero in IDLE, so reset clears them immediately.
  always_comb begin
    IC_GNT_SA    = 1'b0;
    IC_RDATA_SA  = '0;
    IC_VALID_SA  = 1'b0;
    IC_DONE_SA   = 1'b0;
    DC_GNT_SA    = 1'b0;
    DC_RDATA_SA  = '0;
    DC_VALID_SA  = 1'b0;
    DC_DONE_SA   = 1'b0;
    MEM_REQ_SA   = 1'b0;
    MEM_WE_SA    = 1'b0;
    MEM_ADR_SA   = '0;
    MEM_WDATA_SA = '0;
    case (state)
      IC_BURST: begin
        IC_GNT_SA   = 1'b1;
        MEM_REQ_SA  = 1'b1;
        MEM_WE_SA   = we;
        MEM_ADR_SA  = beat_adr;
        IC_VALID_SA = MEM_ACK_SM;
        IC_RDATA_SA = MEM_ACK_SM ? MEM_RDATA_SM : '0;
        IC_DONE_SA  = MEM_ACK_SM && last_beat;
      end
      DC_BURST: begin
        DC_GNT_SA    = 1'b1;
        MEM_REQ_SA   = 1'b1;
        MEM_WE_SA    = we;
        MEM_ADR_SA   = beat_adr;
        MEM_WDATA_SA = we ? DC_WDATA_SI : '0;
        DC_VALID_SA  = MEM_ACK_SM;
        DC_RDATA_SA  = MEM_ACK_SM ? MEM_RDATA_SM : '0;
        DC_DONE_SA   = MEM_ACK_SM && last_beat;
      end
      default: ;
    endcase
  end

endmodule
